// File: rtl/alu.sv
// RV32I integer ALU: funct3/funct7-decoded add/sub, shifts, compares and logic ops.
// The result is registered, giving a fixed one-cycle latency.
package ALU_FNS;
  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_fn_t;

  typedef logic [6:0] funct7_t;

  localparam funct7_t ADD_SRL = 7'b0000000;
  localparam funct7_t SUB_SRA = 7'b0100000;
endpackage

module alu
  import ALU_FNS::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  alu_fn_t          fn,
  input  funct7_t          funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0]   w_shamt;
  logic             w_alt;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_out;

  // Only the low log2(WIDTH) bits of b select the shift distance.
  assign w_shamt = b[ShW-1:0];
  assign w_alt   = (funct7 == SUB_SRA);

  always_comb begin
    w_result = '0;
    unique case (fn)
      ADD_SUB: w_result = w_alt ? (a - b) : (a + b);
      SLL:     w_result = a << w_shamt;
      SLT:     w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    w_result = {{(WIDTH-1){1'b0}}, (a < b)};
      XOR:     w_result = a ^ b;
      SRL_SRA: w_result = w_alt ? $unsigned($signed(a) >>> w_shamt) : (a >> w_shamt);
      OR:      w_result = a | b;
      AND:     w_result = a & b;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_result;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/pipeline sequences and a
// randomised add/sub regression against a simple reference model.
module tb_alu;
  import ALU_FNS::*;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  alu_fn_t       fn;
  funct7_t       funct7;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  out;

  int checks;
  int errors;

  alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .fn     (fn),
    .funct7 (funct7),
    .a      (a),
    .b      (b),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_fn_t      fn;
    funct7_t      f7;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, out, exp);
    end
  endtask

  task automatic drive(input alu_fn_t f, input funct7_t f7, input logic [W-1:0] va,
                       input logic [W-1:0] vb);
    fn     = f;
    funct7 = f7;
    a      = va;
    b      = vb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(alu_fn_t f, funct7_t f7, logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] e);
    vec_t v;
    v.fn  = f;
    v.f7  = f7;
    v.a   = va;
    v.b   = vb;
    v.exp = e;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] pexp[3];

    checks = 0;
    errors = 0;

    vecs.push_back(mk(ADD_SUB, ADD_SRL, 32'hFFFFFFFF, 32'd1, 32'h00000000));
    vecs.push_back(mk(ADD_SUB, ADD_SRL, -32'sd5, 32'd6, 32'h00000001));
    vecs.push_back(mk(ADD_SUB, ADD_SRL, 32'd5, -32'sd6, 32'hFFFFFFFF));
    vecs.push_back(mk(ADD_SUB, SUB_SRA, 32'd5, -32'sd6, 32'h0000000B));
    vecs.push_back(mk(ADD_SUB, SUB_SRA, -32'sd5, 32'd6, 32'hFFFFFFF5));
    vecs.push_back(mk(SLT,     ADD_SRL, 32'hFFFFFFFF, 32'd1, 32'h00000001));
    vecs.push_back(mk(SLTU,    ADD_SRL, 32'hFFFFFFFF, 32'd1, 32'h00000000));
    vecs.push_back(mk(SLT,     ADD_SRL, 32'd7, 32'd7, 32'h00000000));
    vecs.push_back(mk(SLTU,    ADD_SRL, 32'd7, 32'd7, 32'h00000000));
    vecs.push_back(mk(SLTU,    ADD_SRL, 32'd1, 32'hFFFFFFFF, 32'h00000001));
    vecs.push_back(mk(SRL_SRA, SUB_SRA, 32'h80000000, 32'd4, 32'hF8000000));
    vecs.push_back(mk(SRL_SRA, ADD_SRL, 32'h80000000, 32'd4, 32'h08000000));
    vecs.push_back(mk(SLL,     ADD_SRL, 32'd1, 32'd33, 32'h00000002));
    vecs.push_back(mk(SLL,     ADD_SRL, 32'h00000003, 32'd31, 32'h80000000));
    vecs.push_back(mk(SRL_SRA, SUB_SRA, 32'h40000000, 32'd36, 32'h04000000));
    vecs.push_back(mk(AND,     ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F));
    vecs.push_back(mk(OR,      ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF));
    vecs.push_back(mk(XOR,     ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0));
    // Non-SUB_SRA funct7 acts as ADD_SRL; funct7 is ignored by other functions.
    vecs.push_back(mk(ADD_SUB, 7'b0000001, 32'd10, 32'd3, 32'h0000000D));
    vecs.push_back(mk(SRL_SRA, 7'b1000000, 32'h80000000, 32'd1, 32'h40000000));
    vecs.push_back(mk(AND,     SUB_SRA, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF));
    vecs.push_back(mk(SLL,     SUB_SRA, 32'h00000001, 32'd4, 32'h00000010));

    // Reset held for two edges with live operands.
    rst = 1'b1;
    drive(ADD_SUB, ADD_SRL, 32'd5, 32'd6);
    step();
    check("reset_edge1", 32'h0);
    step();
    check("reset_edge2", 32'h0);
    rst = 1'b0;
    step();
    check("reset_release", 32'h0000000B);

    foreach (vecs[i]) begin
      drive(vecs[i].fn, vecs[i].f7, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back logic ops: each result reflects only its own cycle's operands.
    pexp[0] = 32'h00F0000F;
    pexp[1] = 32'hFFF00FFF;
    pexp[2] = 32'hFF000FF0;
    drive(AND, ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F);
    step();
    check("pipe_and", pexp[0]);
    drive(OR, ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F);
    step();
    check("pipe_or", pexp[1]);
    drive(XOR, ADD_SRL, 32'hF0F000FF, 32'h0FF00F0F);
    step();
    check("pipe_xor", pexp[2]);
    drive(ADD_SUB, SUB_SRA, 32'd100, 32'd1);
    step();
    check("pipe_sub", 32'd99);

    // Mid-stream reset discards the in-flight result.
    drive(ADD_SUB, ADD_SRL, 32'd1, 32'd2);
    rst = 1'b1;
    step();
    check("midreset", 32'h0);
    rst = 1'b0;
    step();
    check("midreset_resume", 32'd3);

    // Random add/sub regression.
    for (int k = 0; k < 4000; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k < 2000) begin
        drive(ADD_SUB, ADD_SRL, ra, rb);
        step();
        check("rand_add", ra + rb);
      end else begin
        drive(ADD_SUB, SUB_SRA, ra, rb);
        step();
        check("rand_sub", ra - rb);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
